set_bit_scanner: RTL and testbench
==================================

SET_BIT_SCANNER -- requirements
Module: set_bit_scanner

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: in_valid  in  1  data_in offered.
REQ-004 SHALL have ports: in_ready  out  1  block accepts a word this cycle.
REQ-005 SHALL have ports: data_in  in  32  word to scan.
REQ-006 SHALL have ports: out_valid  out  1  out_index/out_zero/out_last valid.
REQ-007 SHALL have ports: out_ready  in  1  consumer accepts current beat.
REQ-008 SHALL have ports: out_index  out  5  bit position of the current set bit.
REQ-009 SHALL have ports: out_zero  out  1  captured word was all-zero (no set bits).
REQ-010 SHALL have ports: out_last  out  1  current beat is the final beat for the word.
REQ-011 SHALL have ports: busy  out  1  a word is held (state not IDLE).

Function
REQ-012 SHALL implement states IDLE and EMIT; state register, word register and outputs all registered.
REQ-013 IDLE: in_ready=1, out_valid=0; on in_valid&in_ready SHALL load data_in into word register and go to EMIT next cycle.
REQ-014 Latency: out_valid SHALL rise exactly one cycle after the accepting edge.
REQ-015 EMIT, nonzero word: out_index SHALL be position of lowest set bit of word register; out_zero=0.
REQ-016 EMIT, zero word: SHALL emit exactly one beat with out_index=0, out_zero=1, out_last=1.
REQ-017 out_last SHALL be 1 iff word register has at most one set bit.
REQ-018 On out_valid&out_ready with out_last=0, SHALL clear the emitted bit; next beat presented the following cycle (one beat per cycle sustained).
REQ-019 On out_valid&out_ready with out_last=1, SHALL return to IDLE next cycle; in_ready high that cycle (no same-cycle reload, one bubble between words).
REQ-020 out_valid=1 with out_ready=0: out_index, out_zero, out_last SHALL hold stable until accepted.
REQ-021 in_ready SHALL be 0 in EMIT; in_valid and data_in ignored there.
REQ-022 Beats per word SHALL equal popcount(word), or 1 if word is zero; indices strictly ascending.
REQ-023 Bit 31 SHALL be handled as any other bit (out_index=31, no wrap).

Reset
REQ-024 reset SHALL be sampled only on rising clock edge and override all other inputs.
REQ-025 Reset values: state=IDLE, word register=0, in_ready=1 from first cycle after reset, out_valid=0, out_index=0, out_zero=0, out_last=0, busy=0.
REQ-026 reset asserted mid-word SHALL discard remaining beats; no further beats for that word.

Configuration
REQ-027 Macro SCAN_POPCOUNT_EN defined: SHALL add output pop_count [5:0], the popcount of the captured word (0..32), registered at capture, constant through EMIT, 0 on reset.
REQ-028 SCAN_POPCOUNT_EN undefined: pop_count port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 reset 2 cycles, then idle -> in_ready=1, out_valid=0, busy=0, all outputs 0.
REQ-030 data_in=32'h8000_0011, out_ready=1 constant -> beats (index,last) = (0,0),(4,0),(31,1) on 3 consecutive cycles, then in_ready=1; pop_count=3 if enabled.
REQ-031 data_in=32'h0000_0000 -> single beat out_zero=1, out_index=0, out_last=1; pop_count=0 if enabled.
REQ-032 data_in=32'hFFFF_FFFF, out_ready toggled 1/0 each cycle -> 32 beats indices 0..31, each held while out_ready=0, last only on 31; pop_count=32 if enabled.
REQ-033 data_in=32'h0000_0F00, reset pulsed after beat index 9 accepted -> no further beats, IDLE next cycle, new word 32'h2 yields one beat index 1, last=1.
REQ-034 in_valid held with changing data_in during EMIT of 32'h0000_0003 -> changes ignored, beats 0 then 1 only.

Source files
------------

// File: rtl/set_bit_scanner.sv
// Set-bit scanner: captures a 32-bit word, emits one beat per set bit, lowest index first (SCAN_POPCOUNT_EN adds pop_count).
// Latency: first beat one cycle after capture; one beat per cycle sustained; one idle bubble between words.
// Backpressure: a beat holds while out_ready is low; in_ready is low for the whole time a word is held.
module set_bit_scanner (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic        out_zero,
  output logic        out_last,
  output logic        busy
`ifdef SCAN_POPCOUNT_EN
  ,
  output logic [5:0]  pop_count
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [31:0] word_cleared;
  logic [4:0]  index_q, index_d;
  logic        zero_q, zero_d;
  logic        last_q, last_d;

  function automatic logic [4:0] lsb_index(input logic [31:0] w);
    lsb_index = '0;
    for (int i = 31; i >= 0; i--) begin
      if (w[i]) lsb_index = i[4:0];
    end
  endfunction

  // True for zero or one set bit: the beat taken from such a word is its final one.
  function automatic logic at_most_one(input logic [31:0] w);
    at_most_one = ((w & (w - 32'd1)) == 32'd0);
  endfunction

  assign word_cleared = word_q & (word_q - 32'd1);

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    index_d = index_q;
    zero_d  = zero_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      if (in_valid) begin
        state_d = EMIT;
        word_d  = data_in;
        index_d = lsb_index(data_in);
        zero_d  = (data_in == 32'd0);
        last_d  = at_most_one(data_in);
      end
    end else if (out_ready) begin
      if (last_q) begin
        state_d = IDLE;
        word_d  = '0;
        index_d = '0;
        zero_d  = 1'b0;
        last_d  = 1'b0;
      end else begin
        word_d  = word_cleared;
        index_d = lsb_index(word_cleared);
        zero_d  = 1'b0;
        last_d  = at_most_one(word_cleared);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= '0;
      index_q <= '0;
      zero_q  <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      index_q <= index_d;
      zero_q  <= zero_d;
      last_q  <= last_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_index = index_q;
  assign out_zero  = zero_q;
  assign out_last  = last_q;

`ifdef SCAN_POPCOUNT_EN
  function automatic logic [5:0] popcount(input logic [31:0] w);
    popcount = '0;
    for (int i = 0; i < 32; i++) begin
      popcount = popcount + {5'd0, w[i]};
    end
  endfunction

  logic [5:0] pop_q;

  // Counted once at capture and held until the next word is taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      pop_q <= '0;
    end else if (state_q == IDLE && in_valid) begin
      pop_q <= popcount(data_in);
    end
  end

  assign pop_count = pop_q;
`endif

endmodule

// File: tb/tb_set_bit_scanner.sv
// Bench for set_bit_scanner: directed words plus random words and random out_ready,
// checked against a per-word list of expected set-bit positions.
module tb_set_bit_scanner;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic        out_zero;
  logic        out_last;
  logic        busy;
`ifdef SCAN_POPCOUNT_EN
  logic [5:0]  pop_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  set_bit_scanner dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_zero  (out_zero),
    .out_last  (out_last),
    .busy      (busy)
`ifdef SCAN_POPCOUNT_EN
    ,
    .pop_count (pop_count)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1);
    check_eq({tag, "_out_valid"}, out_valid, 0);
    check_eq({tag, "_busy"}, busy, 0);
  endtask

  // rdy_mode: 0 always ready, 1 toggle starting low, 2 random.
  // noise keeps in_valid high with changing data_in while the word is held.
  // abort_at >= 0 pulses reset once that many beats have been accepted.
  task automatic run_word(input logic [31:0] w, input int rdy_mode, input bit noise, input int abort_at);
    int exp_idx[$];
    int k;
    int n;
    int guard;
    bit rdy;
    bit is_zero;
    for (int i = 0; i < 32; i++) if (w[i]) exp_idx.push_back(i);
    is_zero = (exp_idx.size() == 0);
    if (is_zero) exp_idx.push_back(0);
    n = exp_idx.size();

    check_idle_outputs("pre");
    in_valid  = 1'b1;
    data_in   = w;
    out_ready = 1'b0;
    @(negedge clock);
    if (!noise) in_valid = 1'b0;

    k = 0;
    guard = 0;
    while (k < n && guard < 400) begin
      if (k == abort_at) begin
        reset = 1'b1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        check_idle_outputs("abort");
        check_eq("abort_index", out_index, 0);
        check_eq("abort_last", out_last, 0);
        @(negedge clock);
        check_idle_outputs("abort_after");
        return;
      end
      check_eq("out_valid", out_valid, 1);
      check_eq("out_index", out_index, exp_idx[k]);
      check_eq("out_zero", out_zero, is_zero);
      check_eq("out_last", out_last, (k == n - 1));
      check_eq("busy", busy, 1);
      check_eq("in_ready_emit", in_ready, 0);
`ifdef SCAN_POPCOUNT_EN
      check_eq("pop_count", pop_count, $countones(w));
`endif
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2 == 1);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      out_ready = rdy;
      if (noise) data_in = $urandom;
      @(negedge clock);
      guard++;
      if (rdy) k++;
    end
    check_eq("beat_count", k, n);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_idle_outputs("done");
  endtask

  initial begin
    logic [31:0] w;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("reset");
    check_eq("reset_index", out_index, 0);
    check_eq("reset_zero", out_zero, 0);
    check_eq("reset_last", out_last, 0);
`ifdef SCAN_POPCOUNT_EN
    check_eq("reset_pop", pop_count, 0);
`endif

    run_word(32'h8000_0011, 0, 1'b0, -1);
    run_word(32'h0000_0000, 0, 1'b0, -1);
    run_word(32'hFFFF_FFFF, 1, 1'b0, -1);
    run_word(32'h0000_0F00, 0, 1'b0, 2);
    run_word(32'h0000_0002, 0, 1'b0, -1);
    run_word(32'h0000_0003, 0, 1'b1, -1);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       w = $urandom;
        1:       w = $urandom & $urandom & $urandom;
        2:       w = 32'h1 << $urandom_range(0, 31);
        default: w = ($urandom_range(0, 1) == 1) ? 32'h0 : 32'h8000_0000;
      endcase
      run_word(w, $urandom_range(0, 2), ($urandom_range(0, 3) == 0), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
